// File: rtl/cmp_result_monitor.sv
// Monitor for a magnitude comparator's less/equal/greater flags. It keeps saturating
// per-outcome counts, detects equal-lock, flags direction crossings and reports malformed samples.
module cmp_result_monitor #(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  input  logic             clear,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] equal_cnt,
  output logic [CNT_W-1:0] greater_cnt,
  output logic             locked,
  output logic [1:0]       state,
  output logic             cross_up,
  output logic             cross_down,
  output logic             err_onehot
);

  localparam int RUN_W = $clog2(STABLE_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_LESS = 2'd1, DIR_GREATER = 2'd2} dir_t;

  function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_run_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + RUN_W'(1);
  endfunction

  state_t           state_q, state_nx;
  dir_t             dir_q, dir_nx;
  logic [RUN_W-1:0] run_q, run_nx;
  logic             cross_up_nx, cross_down_nx;
  logic             onehot, sample_ok, sample_bad;

  assign onehot     = $onehot({less, equal, greater});
  assign sample_ok  = in_valid & ~clear & onehot;
  assign sample_bad = in_valid & ~clear & ~onehot;

  // State, run counter and registered locked flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_nx;
      run_q   <= run_nx;
      locked  <= (state_nx == LOCKED);
    end
  end

  always_comb begin
    state_nx = state_q;
    run_nx   = run_q;
    if (clear) begin
      state_nx = IDLE;
      run_nx   = '0;
    end else if (sample_ok) begin
      if (equal) begin
        case (state_q)
          IDLE: begin
            run_nx   = RUN_W'(1);
            state_nx = (STABLE_N == 1) ? LOCKED : TRACK;
          end
          TRACK: begin
            run_nx   = sat_run_inc(run_q);
            state_nx = (run_nx == RUN_MAX) ? LOCKED : TRACK;
          end
          LOCKED:  state_nx = LOCKED;
          default: begin
            state_nx = IDLE;
            run_nx   = '0;
          end
        endcase
      end else begin
        run_nx   = '0;
        state_nx = TRACK;
      end
    end
  end

  // Direction memory and crossing pulses; equal samples leave the direction untouched
  always_comb begin
    dir_nx        = dir_q;
    cross_up_nx   = 1'b0;
    cross_down_nx = 1'b0;
    if (clear) begin
      dir_nx = DIR_NONE;
    end else if (sample_ok && !equal) begin
      cross_up_nx   = greater & (dir_q == DIR_LESS);
      cross_down_nx = less & (dir_q == DIR_GREATER);
      dir_nx        = less ? DIR_LESS : DIR_GREATER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= DIR_NONE;
      cross_up   <= 1'b0;
      cross_down <= 1'b0;
      err_onehot <= 1'b0;
    end else begin
      dir_q      <= dir_nx;
      cross_up   <= cross_up_nx;
      cross_down <= cross_down_nx;
      if (clear)           err_onehot <= 1'b0;
      else if (sample_bad) err_onehot <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      less_cnt    <= '0;
      equal_cnt   <= '0;
      greater_cnt <= '0;
    end else if (clear) begin
      less_cnt    <= '0;
      equal_cnt   <= '0;
      greater_cnt <= '0;
    end else if (sample_ok) begin
      if (less)    less_cnt    <= sat_cnt_inc(less_cnt);
      if (equal)   equal_cnt   <= sat_cnt_inc(equal_cnt);
      if (greater) greater_cnt <= sat_cnt_inc(greater_cnt);
    end
  end

  assign state = state_q;

endmodule

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
Downstream consumer of the N-bit magnitude comparator's less/equal/greater flags. Samples one flag triple per valid strobe and keeps saturating per-outcome counters. Detects a stable "equal" lock after STABLE_N consecutive equal samples and flags direction crossings (less to greater, greater to less). Flags malformed (non-one-hot) flag triples. Feeds status and statistics to the control/debug logic.

Parameters:
CNT_W, 8, width of each saturating outcome counter (>=1)
STABLE_N, 3, consecutive valid equal samples required to assert lock (>=1)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sample strobe; flags are consumed only when 1
less  input  1  comparator flag a<b
equal  input  1  comparator flag a==b
greater  input  1  comparator flag a>b
clear  input  1  synchronous clear of counters, error flag and FSM
less_cnt  output  CNT_W  saturating count of valid less samples
equal_cnt  output  CNT_W  saturating count of valid equal samples
greater_cnt  output  CNT_W  saturating count of valid greater samples
locked  output  1  high while FSM is in LOCKED
state  output  2  FSM state: IDLE=0, TRACK=1, LOCKED=2 (3 unused)
cross_up  output  1  one-cycle pulse on a less-to-greater crossing
cross_down  output  1  one-cycle pulse on a greater-to-less crossing
err_onehot  output  1  sticky: a valid sample was not exactly one-hot

Behaviour:
- Reset: rst_n is asynchronous and active-low. While rst_n=0, all outputs are 0, state=IDLE, the equal-run counter is 0 and last_dir=NONE.
- All outputs are registered. A sample at edge k is reflected in the outputs immediately after edge k (1-cycle latency).
- Sample accepted: in_valid=1, clear=0 and exactly one flag high. in_valid=0 cycles hold all state and do not break an equal run.
- Malformed sample: in_valid=1 with zero flags or more than one flag high. Sets err_onehot. Counters, FSM, run counter and last_dir are unchanged. No cross pulse.
- Counters: the matching counter increments by 1 on each accepted sample and saturates at 2^CNT_W-1. It never wraps.
- Clear: has priority over in_valid in the same cycle. Zeros all counters, err_onehot, the run counter and the cross pulses. Sets last_dir=NONE and state=IDLE.
- Run counter width: clog2(STABLE_N+1). It saturates at STABLE_N.
- FSM transitions (on accepted samples only):
  - IDLE, equal: run=1. Go to LOCKED if STABLE_N==1, else to TRACK.
  - IDLE, non-equal: run=0, go to TRACK.
  - TRACK, equal: run+1. Go to LOCKED when run+1 reaches STABLE_N.
  - TRACK, non-equal: run=0, stay in TRACK.
  - LOCKED, equal: stay in LOCKED.
  - LOCKED, non-equal: run=0, go to TRACK.
- locked = (state==LOCKED), registered.
- last_dir: holds the most recent non-equal direction (NONE, LESS or GREATER). Equal samples leave it unchanged.
- cross_up=1 for exactly one cycle when an accepted greater sample arrives with last_dir=LESS.
- cross_down=1 for exactly one cycle when an accepted less sample arrives with last_dir=GREATER.
- Both cross pulses are 0 in every other cycle, including when last_dir=NONE.

Test Plan:
1. Reset mid-run: CNT_W=4, STABLE_N=3. Apply 2 valid equal samples, then drive rst_n=0 asynchronously between edges -> all outputs 0 and state=0 without waiting for a clock edge. After release, the next equal sample gives state=1 and equal_cnt=1.
2. Lock and unlock: 3 valid equal samples -> after the 3rd edge locked=1, state=2, equal_cnt=3. Then valid less -> locked=0, state=1, less_cnt=1.
3. Run rules: equal, in_valid=0 for 2 cycles, equal, equal -> locked=1 (gaps tolerated). After clear, the sequence equal, equal, less, equal -> locked stays 0 and state=1.
4. Crossings: less, equal, greater -> cross_up=1 for exactly the one cycle after the greater sample. Then greater, less -> cross_down=1 for one cycle. A first-ever sample of greater after reset -> no pulse.
5. Saturation: CNT_W=4, 20 consecutive valid greater samples -> greater_cnt=15 and holds. less_cnt=0 and equal_cnt=0.
6. Malformed and clear: valid with less=1 and greater=1 -> err_onehot=1, counters and state unchanged. Next, clear=1 together with a valid equal sample -> all counters 0, err_onehot=0, state=0.
